// File: rtl/module_codificador_hamming.sv
// Hamming(7,4) encoder and LSB-first serial transmitter.
// Accepts a 4-bit word on a valid/ready handshake. It builds the codeword
// {d4,d3,d2,p4,d1,p2,p1}, can flip one selected bit for corrector testing,
// and shifts the word out holding each bit for BIT_CYCLES clock cycles.
// Ports:
//   clk, rst_n      : clock (rising edge) and asynchronous active-low reset
//   datos_in        : data word, datos_in[0]=d1 .. datos_in[3]=d4
//   datos_valid     : datos_in valid
//   datos_ready     : encoder idle and able to accept a word
//   inyectar_error  : enables single-bit error injection (sampled on accept)
//   pos_error       : position 1..7 of the bit to flip, 0 = no flip
//   codigo          : latched transmitted codeword (codigo[0] = position 1)
//   serial_out      : current serial bit
//   serial_valid    : serial_out carries a codeword bit
//   serial_last     : serial_out carries position 7
//   busy            : transmission in progress
//   palabras_cnt    : number of accepted words (wraps)
module module_codificador_hamming #(
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       datos_in,
  input  logic             datos_valid,
  output logic             datos_ready,
  input  logic             inyectar_error,
  input  logic [2:0]       pos_error,
  output logic [6:0]       codigo,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             serial_last,
  output logic             busy,
  output logic [CNT_W-1:0] palabras_cnt
);

  localparam int unsigned CW_W     = 7;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned CYC_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int unsigned LAST_IDX = CW_W - 1;

  typedef enum logic [0:0] {IDLE, SHIFT} state_e;

  state_e              state_q, state_d;
  logic [CW_W-1:0]     codigo_q, codigo_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [CYC_W-1:0]    cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0]    palabras_cnt_q, palabras_cnt_d;
  logic                datos_ready_q, datos_ready_d;
  logic                serial_out_q, serial_out_d;
  logic                serial_valid_q, serial_valid_d;
  logic                serial_last_q, serial_last_d;
  logic                busy_q, busy_d;

  logic                p1, p2, p4;
  logic [CW_W-1:0]     enc;
  logic [CW_W-1:0]     shifted;

  // Encoder with optional single-bit flip, evaluated from the live inputs.
  always_comb begin
    p1  = datos_in[0] ^ datos_in[1] ^ datos_in[3];
    p2  = datos_in[0] ^ datos_in[2] ^ datos_in[3];
    p4  = datos_in[1] ^ datos_in[2] ^ datos_in[3];
    enc = {datos_in[3], datos_in[2], datos_in[1], p4, datos_in[0], p2, p1};
    if (inyectar_error) begin
      for (int i = 0; i < CW_W; i++) begin
        if (pos_error == 3'(i + 1)) enc[i] = ~enc[i];
      end
    end
  end

  // Next-state logic; output flops are loaded from the next state so the
  // first bit appears in the cycle right after the accept edge.
  always_comb begin
    state_d        = state_q;
    codigo_d       = codigo_q;
    bit_idx_d      = bit_idx_q;
    cyc_cnt_d      = cyc_cnt_q;
    palabras_cnt_d = palabras_cnt_q;

    case (state_q)
      IDLE: begin
        if (datos_valid) begin
          state_d        = SHIFT;
          codigo_d       = enc;
          bit_idx_d      = '0;
          cyc_cnt_d      = '0;
          palabras_cnt_d = palabras_cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cyc_cnt_q == CYC_W'(BIT_CYCLES - 1)) begin
          cyc_cnt_d = '0;
          if (bit_idx_q == IDX_W'(LAST_IDX)) begin
            state_d = IDLE;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    shifted        = codigo_d >> bit_idx_d;
    serial_valid_d = (state_d == SHIFT);
    busy_d         = (state_d == SHIFT);
    datos_ready_d  = (state_d == IDLE);
    serial_out_d   = (state_d == SHIFT) & shifted[0];
    serial_last_d  = (state_d == SHIFT) && (bit_idx_d == IDX_W'(LAST_IDX));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      codigo_q       <= '0;
      bit_idx_q      <= '0;
      cyc_cnt_q      <= '0;
      palabras_cnt_q <= '0;
      datos_ready_q  <= 1'b1;
      serial_out_q   <= 1'b0;
      serial_valid_q <= 1'b0;
      serial_last_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      codigo_q       <= codigo_d;
      bit_idx_q      <= bit_idx_d;
      cyc_cnt_q      <= cyc_cnt_d;
      palabras_cnt_q <= palabras_cnt_d;
      datos_ready_q  <= datos_ready_d;
      serial_out_q   <= serial_out_d;
      serial_valid_q <= serial_valid_d;
      serial_last_q  <= serial_last_d;
      busy_q         <= busy_d;
    end
  end

  assign datos_ready  = datos_ready_q;
  assign codigo       = codigo_q;
  assign serial_out   = serial_out_q;
  assign serial_valid = serial_valid_q;
  assign serial_last  = serial_last_q;
  assign busy         = busy_q;
  assign palabras_cnt = palabras_cnt_q;

endmodule

// File: tb/tb_module_codificador_hamming.sv
// Bench for module_codificador_hamming: two instances share the inputs
// (BIT_CYCLES=1/CNT_W=8 and BIT_CYCLES=3/CNT_W=2) and are checked against a
// positional Hamming reference model and a syndrome-based decoder.
module tb_module_codificador_hamming;

  logic       clk;
  logic       rst_n;
  logic [3:0] datos_in;
  logic       datos_valid;
  logic       inyectar_error;
  logic [2:0] pos_error;

  logic       ready1, so1, sv1, sl1, busy1;
  logic [6:0] codigo1;
  logic [7:0] cnt1;
  logic       ready3, so3, sv3, sl3, busy3;
  logic [6:0] codigo3;
  logic [1:0] cnt3;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_cnt1;
  logic [1:0] exp_cnt3;

  module_codificador_hamming #(.BIT_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .datos_in(datos_in), .datos_valid(datos_valid),
    .datos_ready(ready1), .inyectar_error(inyectar_error), .pos_error(pos_error),
    .codigo(codigo1), .serial_out(so1), .serial_valid(sv1), .serial_last(sl1),
    .busy(busy1), .palabras_cnt(cnt1)
  );

  module_codificador_hamming #(.BIT_CYCLES(3), .CNT_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .datos_in(datos_in), .datos_valid(datos_valid),
    .datos_ready(ready3), .inyectar_error(inyectar_error), .pos_error(pos_error),
    .codigo(codigo3), .serial_out(so3), .serial_valid(sv3), .serial_last(sl3),
    .busy(busy3), .palabras_cnt(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Positional Hamming code: data fills non-power-of-two positions in order,
  // parity at position 2^b covers every position whose index has bit b set.
  function automatic logic [6:0] model(input logic [3:0] d, input logic inj,
                                       input logic [2:0] pos);
    logic [6:0] c;
    int k;
    logic par;
    c = '0;
    k = 0;
    for (int p = 1; p <= 7; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 3; b++) begin
      par = 1'b0;
      for (int p = 1; p <= 7; p++) if (((p >> b) & 1) == 1) par ^= c[p-1];
      c[(1 << b) - 1] = par;
    end
    if (inj && pos != 3'd0) c[int'(pos) - 1] = ~c[int'(pos) - 1];
    return c;
  endfunction

  // Receive-side correction: syndrome is the XOR of the indices of set bits.
  function automatic logic [3:0] decode(input logic [6:0] c);
    int s;
    logic [6:0] f;
    s = 0;
    f = c;
    for (int p = 1; p <= 7; p++) if (c[p-1]) s ^= p;
    if (s != 0) f[s-1] = ~f[s-1];
    return {f[6], f[5], f[4], f[2]};
  endfunction

  // Expected {ready, busy, valid, last, serial} c cycles after an accept.
  function automatic logic [4:0] exp_vec(input logic [6:0] cw, input int c,
                                         input int bc);
    logic shifting;
    int b;
    shifting = (c < 7 * bc);
    b = c / bc;
    if (!shifting) return 5'b10000;
    return {1'b0, 1'b1, 1'b1, (b == 6), cw[b]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_reset_values();
    chk("rst_vec1", 32'({ready1, busy1, sv1, sl1, so1}), 32'(5'b10000));
    chk("rst_vec3", 32'({ready3, busy3, sv3, sl3, so3}), 32'(5'b10000));
    chk("rst_codigo", 32'({codigo1, codigo3}), 32'd0);
    chk("rst_cnt", 32'({cnt1, cnt3}), 32'd0);
  endtask

  // One accepted word, checked cycle by cycle on both instances; abort_at>=0
  // pulls rst_n low at that cycle after the accept.
  task automatic send(input logic [3:0] d, input logic inj, input logic [2:0] pos,
                      input int abort_at);
    logic [6:0] cw;
    cw = model(d, inj, pos);
    chk("ready_before", 32'({ready1, ready3}), 32'(2'b11));
    datos_in = d;
    inyectar_error = inj;
    pos_error = pos;
    datos_valid = 1'b1;
    @(negedge clk);
    datos_valid = 1'b0;
    datos_in = 4'($urandom);
    inyectar_error = 1'($urandom);
    pos_error = 3'($urandom);
    exp_cnt1 = exp_cnt1 + 8'd1;
    exp_cnt3 = exp_cnt3 + 2'd1;
    chk("codigo1", 32'(codigo1), 32'(cw));
    chk("codigo3", 32'(codigo3), 32'(cw));
    chk("cnt1", 32'(cnt1), 32'(exp_cnt1));
    chk("cnt3", 32'(cnt3), 32'(exp_cnt3));
    chk("decode", 32'(decode(codigo1)), 32'(d));
    for (int c = 0; c <= 21; c++) begin
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst", 32'({sv1, busy1, sl1, so1, sv3, busy3, sl3, so3}), 32'd0);
        chk("async_rst_codigo", 32'({codigo1, codigo3}), 32'd0);
        chk("async_rst_cnt", 32'({cnt1, cnt3}), 32'd0);
        exp_cnt1 = '0;
        exp_cnt3 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_reset_values();
        return;
      end
      chk($sformatf("bits1_c%0d", c), 32'({ready1, busy1, sv1, sl1, so1}),
          32'(exp_vec(cw, c, 1)));
      chk($sformatf("bits3_c%0d", c), 32'({ready3, busy3, sv3, sl3, so3}),
          32'(exp_vec(cw, c, 3)));
      @(negedge clk);
    end
    chk("codigo_hold", 32'({codigo1, codigo3}), 32'({cw, cw}));
  endtask

  initial begin
    logic [3:0] d;
    logic       inj;
    logic [2:0] pos;
    int acc1, acc3, first3, second3, n;

    rst_n = 1'b0;
    datos_in = '0;
    datos_valid = 1'b0;
    inyectar_error = 1'b0;
    pos_error = '0;
    exp_cnt1 = '0;
    exp_cnt3 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_reset_values();

    // Directed words with known codewords; CNT_W=2 counter runs 1,2,3,0,1.
    send(4'b0001, 1'b0, 3'd0, -1);
    chk("lit_0001", 32'(codigo1), 32'(7'b0000111));
    send(4'b1111, 1'b0, 3'd0, -1);
    chk("lit_1111", 32'(codigo1), 32'(7'b1111111));
    send(4'b0110, 1'b0, 3'd0, -1);
    chk("lit_0110", 32'(codigo1), 32'(7'b0110011));
    send(4'b0000, 1'b1, 3'd1, -1);
    chk("lit_inj1", 32'(codigo1), 32'(7'b0000001));
    send(4'b0001, 1'b1, 3'd3, -1);
    chk("lit_inj3", 32'(codigo1), 32'(7'b0000011));
    send(4'b0001, 1'b1, 3'd0, -1);
    chk("lit_inj0", 32'(codigo1), 32'(7'b0000111));
    send(4'b0001, 1'b0, 3'd5, -1);
    chk("lit_noinj", 32'(codigo1), 32'(7'b0000111));

    // datos_valid held high: slow instance accepts at cycles 0 and 22 only.
    d = 4'($urandom);
    datos_in = d;
    inyectar_error = 1'b0;
    pos_error = '0;
    datos_valid = 1'b1;
    acc1 = 0;
    acc3 = 0;
    first3 = -1;
    second3 = -1;
    for (int i = 0; i < 44; i++) begin
      if (ready1) acc1++;
      if (ready3) begin
        if (acc3 == 0) first3 = i;
        else if (acc3 == 1) second3 = i;
        acc3++;
      end
      @(negedge clk);
    end
    datos_valid = 1'b0;
    chk("hold_acc3", 32'(acc3), 32'd2);
    chk("hold_spacing3", 32'(second3 - first3), 32'd22);
    chk("hold_acc1", 32'(acc1), 32'd6);
    exp_cnt1 = exp_cnt1 + 8'd6;
    exp_cnt3 = exp_cnt3 + 2'd2;
    n = 0;
    while (!(ready1 && ready3) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hold_idle", 32'({ready1, ready3}), 32'(2'b11));
    chk("hold_codigo", 32'({codigo1, codigo3}), 32'({model(d, 1'b0, 3'd0), model(d, 1'b0, 3'd0)}));
    chk("hold_cnt", 32'({cnt1, cnt3}), 32'({exp_cnt1, exp_cnt3}));

    // Randomized words and injections.
    for (int t = 0; t < 24; t++) begin
      d = 4'($urandom);
      inj = 1'($urandom);
      pos = 3'($urandom_range(0, 7));
      send(d, inj, pos, -1);
    end

    // Reset during bit 3 of the slow instance, then a clean word afterwards.
    send(4'($urandom), 1'b0, 3'd0, 10);
    send(4'b1010, 1'b0, 3'd0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
